// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART slice.
//   UART_DATA_WIDTH  default bits per UART character
//   PARITY_*         parity-mode encodings used by receiver/transmitter
//   uart_fifo_entry_t  receive FIFO entry layout {perr, data}
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef struct packed {
    logic                       perr;
    logic [UART_DATA_WIDTH-1:0] data;
  } uart_fifo_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port storage array for the receive FIFO.
// Synchronous write, asynchronous read (distributed-RAM style). Not reset.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer downstream of the UART receiver.
// Captures a byte on each wr_en (rx_done) pulse, optionally tags it with the
// frame's parity-error status, and presents entries show-ahead to a consumer.
// Optional feature macro: UART_RX_FIFO_PERR_EN (parity tag storage/output).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en/wr_data   write strobe and received byte
//   wr_perr         parity-error pulse, may precede its wr_en
//   rd_valid/rd_ready/rd_data/rd_perr  head entry handshake
//   count/full/empty  fill level and flags
//   overflow/clr_overflow  sticky drop flag and its clear
// Handshake: a read transfer happens in every cycle where rd_valid and
// rd_ready are both high; rd_valid never depends on rd_ready, and
// rd_data/rd_perr are stable while rd_valid is high and no transfer occurs.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_perr,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_overflow
);

`ifdef UART_RX_FIFO_PERR_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          rd_fire, wr_fire, wr_drop;
  logic [EW-1:0] mem_wdata, mem_rdata;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign rd_valid = !empty;
  assign count    = count_q;
  assign overflow = overflow_q;

  assign rd_fire = rd_valid && rd_ready;
  // A full FIFO still accepts a write when the head is popped in that cycle.
  assign wr_fire = wr_en && (!full || rd_fire);
  assign wr_drop = wr_en && full && !rd_fire;

`ifdef UART_RX_FIFO_PERR_EN
  logic perr_pend_q, perr_pend_d;

  // Tag is consumed by any completed byte, accepted or dropped.
  always_comb begin
    perr_pend_d = perr_pend_q;
    if (wr_en)        perr_pend_d = 1'b0;
    else if (wr_perr) perr_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) perr_pend_q <= 1'b0;
    else     perr_pend_q <= perr_pend_d;
  end

  assign mem_wdata = {perr_pend_q | wr_perr, wr_data};
  assign rd_data   = empty ? '0 : mem_rdata[DATA_WIDTH-1:0];
  assign rd_perr   = empty ? 1'b0 : mem_rdata[DATA_WIDTH];
`else
  logic unused_wr_perr;
  assign unused_wr_perr = wr_perr;
  assign mem_wdata = wr_data;
  assign rd_data   = empty ? '0 : mem_rdata;
  assign rd_perr   = 1'b0;
`endif

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_fire) wp_d = wp_q + 1'b1;
    if (rd_fire) rp_d = rp_q + 1'b1;
    if (wr_fire && !rd_fire)      count_d = count_q + 1'b1;
    else if (rd_fire && !wr_fire) count_d = count_q - 1'b1;
    // Setting wins over clearing in the same cycle.
    if (wr_drop)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Memory write is suppressed during reset so a reset-cycle strobe is lost.
  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_fire && !rst),
    .waddr_i (wp_q),
    .wdata_i (mem_wdata),
    .raddr_i (rp_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each completed byte on the receiver's done pulse and tags it with that frame's parity-error status. It holds up to DEPTH bytes and presents them to the consumer (host logic or loopback TX) over a valid/ready handshake. It reports fill level, full/empty, and a sticky overflow flag.

## Interface
- DATA_WIDTH, 8: bits per received word; must match receiver.
- DEPTH, 16: entries; power of two, ≥2.
- AW, $clog2(DEPTH): derived pointer width; not user-set.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe (receiver rx_done).
- wr_data  in  DATA_WIDTH  received byte (receiver dout), valid when wr_en=1.
- wr_perr  in  1  one-cycle parity-error pulse; arrives before the wr_en of the same frame.
- rd_ready  in  1  consumer accepts head entry.
- rd_valid  out  1  head entry available (=!empty).
- rd_data  out  DATA_WIDTH  head entry data; 0 while empty.
- rd_perr  out  1  head entry parity-error tag; 0 while empty.
- count  out  AW+1  entries held, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: a write was dropped.
- clr_overflow  in  1  clears overflow.

## Operation
- Storage: circular buffer, write pointer wp, read pointer rp, both AW bits, wrap modulo DEPTH. count is a separate AW+1 register; full/empty derive from count.
- Parity tagging: perr_pend register set by wr_perr, cleared when a write is accepted or dropped. An accepted write stores {perr_pend | wr_perr, wr_data}. perr_pend is not cleared on framing failure; the next completed byte inherits it.
- Write accepted when wr_en && (!full || read fires same cycle): mem[wp] written, wp+1.
- Write while full with no read same cycle: data dropped, pointers unchanged, overflow←1.
- Read fires when rd_valid && rd_ready: rp+1. Head data is show-ahead: rd_data/rd_perr reflect mem[rp] combinationally.
- count: +1 on write only, −1 on read only, unchanged when both fire or neither fires.
- overflow: set has priority over clr_overflow in the same cycle.
- No write-to-read bypass: a write into an empty FIFO becomes visible the next cycle.
- Reset values: wp=rp=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_perr=0, overflow=0, perr_pend=0. Memory contents are not reset.
- Reset mid-operation: all buffered entries discarded; a wr_en in the reset cycle is ignored.

## Timing
- Write→rd_valid latency: 1 cycle (rd_valid high the cycle after the accepted wr_en into an empty FIFO).
- Read→next head: 1 cycle. Sustained throughput is 1 read/cycle.
- full/empty/count update the cycle after the causing event.
- overflow asserts the cycle after the dropped write and holds until clr_overflow or rst.
- wr_perr may precede its wr_en by any number of cycles. wr_perr and wr_en in the same cycle tag that write.

## Configuration
- UART_RX_FIFO_PERR_EN defined: entries are DATA_WIDTH+1 bits, perr_pend is present, and rd_perr carries the tag.
- Undefined: entries are DATA_WIDTH bits, wr_perr is ignored, perr_pend is absent, and rd_perr is tied 0.

## Structure
- Shared package uart_pkg: UART_DATA_WIDTH=8 default, parity-mode constants PARITY_NONE=2'b00, PARITY_EVEN=2'b01, PARITY_ODD=2'b10, and a fifo-entry struct/typedef {perr, data}.
- Sub-module uart_fifo_mem: simple dual-port array, synchronous write, asynchronous read, parameterised width/depth (maps to distributed RAM).
- Pointer/count/flag logic lives in uart_rx_fifo.

## Test plan
- Reset then single write 0xA5 → next cycle rd_valid=1, rd_data=0xA5, rd_perr=0, count=1. rd_ready=1 → empty=1 the following cycle.
- wr_perr pulse, 3 idle cycles, wr_en 0x3C → head 0x3C with rd_perr=1. The next write of 0x3D has rd_perr=0.
- Write 16 bytes 0x00..0x0F with no reads → full=1, count=16. A 17th write of 0xFF → overflow=1 and count=16. Reads return 0x00..0x0F in order, no 0xFF.
- With full, wr_en 0x55 and rd_ready in the same cycle → head pops, 0x55 accepted, count stays 16, overflow stays 0.
- overflow set, then overflow event and clr_overflow in the same cycle → overflow remains 1. clr_overflow alone → 0.
- 5 entries buffered, rst asserted for 1 cycle → count=0, empty=1, rd_valid=0. Next write 0x77 is the head.
